// File: rtl/operand_serializer_pkg.sv
// Shared definitions for the TPU operand-link serializer.
package operand_serializer_pkg;

    localparam int unsigned D_W_DEF  = 8;
    localparam int unsigned N_DEF    = 2;
    localparam int unsigned WORD_DEF = 8;

    localparam int unsigned BITS    = N_DEF * D_W_DEF;
    localparam int unsigned BIT_CW  = $clog2(BITS);
    localparam int unsigned BEAT_CW = $clog2(WORD_DEF + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_INIT
    } state_t;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register, MSB first, zero fill so the
// serial output idles low once the loaded word has drained.
module piso_shift #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign dout = sr[WIDTH-1];

endmodule

// File: rtl/operand_serializer.sv
// Host-side transmitter: takes X/Y operand vectors over valid/ready and
// streams them bit-serially, then pulses init/done after WORD beats.
module operand_serializer
    import operand_serializer_pkg::*;
#(
    parameter int unsigned D_W  = D_W_DEF,
    parameter int unsigned N    = N_DEF,
    parameter int unsigned WORD = WORD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [N*D_W-1:0] x_vec,
    input  logic [N*D_W-1:0] y_vec,
    output logic             data_in_x,
    output logic             data_in_y,
    output logic             load_en,
    output logic             init,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NBITS  = N * D_W;
    localparam int unsigned CNT_W  = cnt_width(NBITS);
    localparam int unsigned BEAT_W = cnt_width(WORD + 1);

    state_t              state;
    state_t              state_n;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_n;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BEAT_W-1:0]   beat_n;
    logic                load;
    logic                shift;
    logic                hs;
    logic                last_bit;
    logic                more_beats;
    logic                ready_n;
    logic [NBITS-1:0]    x_pk;
    logic [NBITS-1:0]    y_pk;

    assign hs = vec_valid & vec_ready;

    // Word 0 goes into the top bits so it leaves the shifter first.
    always_comb begin
        x_pk = '0;
        y_pk = '0;
        for (int unsigned i = 0; i < N; i++) begin
            x_pk[(N-1-i)*D_W +: D_W] = x_vec[i*D_W +: D_W];
            y_pk[(N-1-i)*D_W +: D_W] = y_vec[i*D_W +: D_W];
        end
    end

    always_comb begin
        state_n    = state;
        bit_n      = bit_cnt;
        beat_n     = beat_cnt;
        load       = 1'b0;
        shift      = 1'b0;
        last_bit   = (bit_cnt == CNT_W'(NBITS - 1));
        more_beats = (beat_cnt < BEAT_W'(WORD));
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_WAIT;
                    beat_n  = '0;
                end
            end
            S_WAIT: begin
                if (hs) begin
                    state_n = S_SHIFT;
                    bit_n   = '0;
                    beat_n  = beat_cnt + BEAT_W'(1);
                    load    = 1'b1;
                end
            end
            S_SHIFT: begin
                shift = 1'b1;
                if (!last_bit) begin
                    bit_n = bit_cnt + CNT_W'(1);
                end else if (hs) begin
                    // Next vector chained with no idle cycle.
                    bit_n  = '0;
                    beat_n = beat_cnt + BEAT_W'(1);
                    load   = 1'b1;
                end else if (more_beats) begin
                    state_n = S_WAIT;
                end else begin
                    state_n = S_INIT;
                end
            end
            S_INIT: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        ready_n = (state_n == S_WAIT) ||
                  ((state_n == S_SHIFT) && (bit_n == CNT_W'(NBITS - 1)) &&
                   (beat_n < BEAT_W'(WORD)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            beat_cnt  <= '0;
            vec_ready <= 1'b0;
            load_en   <= 1'b0;
            init      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_n;
            beat_cnt  <= beat_n;
            vec_ready <= ready_n;
            load_en   <= (state_n == S_SHIFT);
            init      <= (state_n == S_INIT);
            done      <= (state_n == S_INIT);
            busy      <= (state_n != S_IDLE);
        end
    end

    piso_shift #(
        .WIDTH(NBITS)
    ) u_piso_x (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (x_pk),
        .dout  (data_in_x)
    );

    piso_shift #(
        .WIDTH(NBITS)
    ) u_piso_y (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (y_pk),
        .dout  (data_in_y)
    );

endmodule

// File: tb/tb_operand_serializer.sv
// Bench for operand_serializer: a WORD=2 and a WORD=1 instance share stimulus;
// expected per-cycle outputs come from a timeline model built from the vectors.
module tb_operand_serializer;

    localparam int unsigned D_W  = 8;
    localparam int unsigned N    = 2;
    localparam int unsigned BITS = N * D_W;
    localparam int          MAXC = 200;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            vec_valid;
    logic [BITS-1:0] x_vec;
    logic [BITS-1:0] y_vec;

    logic r1, dx1, dy1, le1, in1, bz1, dn1;
    logic r2, dx2, dy2, le2, in2, bz2, dn2;
    logic [6:0] obs1;
    logic [6:0] obs2;

    // Packed observation: {vec_ready, load_en, x, y, init, busy, done}
    assign obs1 = {r1, le1, dx1, dy1, in1, bz1, dn1};
    assign obs2 = {r2, le2, dx2, dy2, in2, bz2, dn2};

    operand_serializer #(.D_W(D_W), .N(N), .WORD(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
        .vec_ready(r1), .x_vec(x_vec), .y_vec(y_vec),
        .data_in_x(dx1), .data_in_y(dy1), .load_en(le1),
        .init(in1), .busy(bz1), .done(dn1)
    );

    operand_serializer #(.D_W(D_W), .N(N), .WORD(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
        .vec_ready(r2), .x_vec(x_vec), .y_vec(y_vec),
        .data_in_x(dx2), .data_in_y(dy2), .load_en(le2),
        .init(in2), .busy(bz2), .done(dn2)
    );

    always #5 clk = ~clk;

    logic [6:0]      exp_q [MAXC];
    logic [BITS-1:0] bx [4];
    logic [BITS-1:0] by [4];
    int              gap [4];
    int              hs_at [4];
    int              t_len;
    int              sel;
    int              n_cmp = 0;
    int              n_err = 0;
    string           tag;

    // Timeline model: handshake cycles from gaps, bits MSB-first per word.
    task automatic build(input int words);
        int h;
        int last;
        int w;
        int k;
        for (int c = 0; c < MAXC; c++) exp_q[c] = '0;
        for (int b = 0; b < words; b++) begin
            h = (b == 0) ? 1 + gap[0] : hs_at[b-1] + int'(BITS) + gap[b];
            hs_at[b] = h;
            for (int c = (b == 0) ? 1 : hs_at[b-1] + int'(BITS); c <= h; c++)
                exp_q[c][6] = 1'b1;
            for (int j = 0; j < int'(BITS); j++) begin
                w = j / int'(D_W);
                k = w * int'(D_W) + int'(D_W) - 1 - (j % int'(D_W));
                exp_q[h+1+j][5] = 1'b1;
                exp_q[h+1+j][4] = bx[b][k];
                exp_q[h+1+j][3] = by[b][k];
            end
        end
        last = hs_at[words-1] + int'(BITS);
        for (int c = 1; c <= last + 1; c++) exp_q[c][1] = 1'b1;
        exp_q[last+1][2] = 1'b1;
        exp_q[last+1][0] = 1'b1;
        t_len = last + 4;
    endtask

    task automatic check(input int c, input logic [6:0] expv);
        logic [6:0] o;
        o = (sel == 1) ? obs1 : obs2;
        n_cmp++;
        assert (o === expv) else begin
            n_err++;
            $error("FAIL %s cycle %0d observed %b expected %b", tag, c, o, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; vec_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Drives cycles [0, ncyc) of the modelled burst, checking each cycle.
    task automatic run(input int words, input int ncyc, input int mid_start, input bit spur);
        for (int c = 0; c < ncyc; c++) begin
            check(c, exp_q[c]);
            start     = (c == 0) || (c == mid_start);
            vec_valid = 1'b0;
            x_vec     = BITS'($urandom);
            y_vec     = BITS'($urandom);
            if (spur && !exp_q[c][6]) vec_valid = 1'($urandom_range(0, 1));
            for (int b = 0; b < words; b++) begin
                if (c == hs_at[b]) begin
                    vec_valid = 1'b1;
                    x_vec     = bx[b];
                    y_vec     = by[b];
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        vec_valid = 1'b0;
    endtask

    task automatic rand_data();
        for (int b = 0; b < 4; b++) begin
            bx[b]  = BITS'($urandom);
            by[b]  = BITS'($urandom);
            gap[b] = 0;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; vec_valid = 1'b0; x_vec = '0; y_vec = '0;
        sel = 2;
        repeat (3) @(negedge clk);

        // Reset held with start asserted: everything stays at reset values.
        tag = "reset";
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        sel = 1; check(0, 7'b0);
        sel = 2; check(0, 7'b0);
        @(negedge clk);
        sel = 1; check(1, 7'b0);
        sel = 2; check(1, 7'b0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        sel = 1; check(2, 7'b0);
        sel = 2; check(2, 7'b0);

        // Single beat on the WORD=1 instance with the known pattern.
        tag = "single"; sel = 1;
        do_reset();
        rand_data();
        bx[0] = 16'hA53C; by[0] = 16'h0F81;
        build(1);
        run(1, t_len, -1, 1'b0);

        // Back-to-back beats with no gap.
        tag = "b2b"; sel = 2;
        do_reset();
        rand_data();
        build(2);
        run(2, t_len, -1, 1'b0);

        // Source stalls five cycles before the second vector.
        tag = "stall";
        do_reset();
        rand_data();
        gap[1] = 5;
        build(2);
        run(2, t_len, -1, 1'b0);

        // Stray start and vec_valid while shifting must be ignored.
        tag = "ignore";
        do_reset();
        rand_data();
        gap[0] = 2; gap[1] = 1;
        build(2);
        run(2, t_len, hs_at[0] + 4, 1'b1);

        // Reset while bit 7 of the first beat is on the line.
        tag = "rstmid";
        do_reset();
        rand_data();
        build(2);
        run(2, hs_at[0] + 8, -1, 1'b0);
        check(hs_at[0] + 8, exp_q[hs_at[0] + 8]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            check(c, 7'b0);
            @(negedge clk);
        end

        // Fresh burst after the aborted one.
        tag = "clean";
        rand_data();
        gap[0] = 1;
        build(2);
        run(2, t_len, -1, 1'b0);

        // Randomized bursts on both instances.
        for (int r = 0; r < 6; r++) begin
            tag = "random";
            sel = (r % 3 == 2) ? 1 : 2;
            do_reset();
            rand_data();
            gap[0] = $urandom_range(0, 3);
            gap[1] = $urandom_range(0, 3);
            build(sel);
            run(sel, t_len, (r % 2 == 1) ? hs_at[0] + 3 : -1, r[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
